// File: rtl/bus_decoder_if.sv
// Core-side request/response and target-side fan-out signals of the bus decoder.
// The slave modport is the decoder's view; master is the core/target environment.
interface bus_decoder_if;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        req_ready;

    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic [3:0]  t_sel;
    logic        t_we;
    logic [31:0] t_addr;
    logic [31:0] t_wdata;
    logic [3:0]  t_wstrb;
    logic [3:0]  t_ack;
    logic [31:0] t_rdata0;
    logic [31:0] t_rdata1;
    logic [31:0] t_rdata2;
    logic [31:0] t_rdata3;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output t_sel, t_we, t_addr, t_wdata, t_wstrb,
        input  t_ack, t_rdata0, t_rdata1, t_rdata2, t_rdata3
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  t_sel, t_we, t_addr, t_wdata, t_wstrb,
        output t_ack, t_rdata0, t_rdata1, t_rdata2, t_rdata3
    );
endinterface

// File: rtl/bus_decoder.sv
// Single-outstanding-request address decoder and response router: one core
// request is steered to one of four targets, then an ack or timeout is returned.
module bus_decoder #(
    parameter logic [3:0]  T0_BASE = 4'h0,
    parameter logic [3:0]  T1_BASE = 4'h1,
    parameter logic [3:0]  T2_BASE = 4'h2,
    parameter logic [3:0]  T3_BASE = 4'h3,
    parameter int unsigned TIMEOUT = 15
) (
    input logic          clk,
    input logic          reset,
    bus_decoder_if.slave bus
);
    localparam int unsigned CNT_W = 8;
    localparam int unsigned DW    = 32;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [DW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic [1:0]      sel_idx_q, sel_idx_d;
    logic [3:0]      t_sel_q, t_sel_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;

    logic            dec_hit;
    logic [1:0]      dec_idx;
    logic            ack_sel;
    logic [DW-1:0]   rdata_sel;

    // Address decode; the if-chain gives the lowest-numbered target priority.
    always_comb begin
        dec_hit = 1'b1;
        dec_idx = 2'd0;
        if (bus.req_addr[31:28] == T0_BASE)      dec_idx = 2'd0;
        else if (bus.req_addr[31:28] == T1_BASE) dec_idx = 2'd1;
        else if (bus.req_addr[31:28] == T2_BASE) dec_idx = 2'd2;
        else if (bus.req_addr[31:28] == T3_BASE) dec_idx = 2'd3;
        else                                     dec_hit = 1'b0;
    end

    always_comb begin
        ack_sel = bus.t_ack[sel_idx_q];
        case (sel_idx_q)
            2'd0:    rdata_sel = bus.t_rdata0;
            2'd1:    rdata_sel = bus.t_rdata1;
            2'd2:    rdata_sel = bus.t_rdata2;
            default: rdata_sel = bus.t_rdata3;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            sel_idx_q   <= '0;
            t_sel_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            sel_idx_q   <= sel_idx_d;
            t_sel_q     <= t_sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        sel_idx_d   = sel_idx_q;
        t_sel_d     = '0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    wstrb_d = bus.req_wstrb;
                    if (dec_hit) begin
                        state_d   = ACCESS;
                        cnt_d     = '0;
                        sel_idx_d = dec_idx;
                        t_sel_d   = 4'(1) << dec_idx;
                    end else begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end
                end
            end
            ACCESS: begin
                if (ack_sel) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = we_q ? '0 : rdata_sel;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == TIMEOUT_C) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        t_sel_d = t_sel_q;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // req_ready is the only output allowed a combinational term (reset).
    assign bus.req_ready = (state_q == IDLE) && !reset;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.t_sel     = t_sel_q;
    assign bus.t_we      = we_q;
    assign bus.t_addr    = addr_q;
    assign bus.t_wdata   = wdata_q;
    assign bus.t_wstrb   = wstrb_q;
endmodule

// File: tb/tb_bus_decoder.sv
// Directed, table-driven bench for bus_decoder with hand-computed expectations
// plus hand-written reset sequences.
module tb_bus_decoder;
    logic clk = 1'b0;
    logic reset;

    bus_decoder_if bus ();

    bus_decoder #(
        .T0_BASE(4'h0), .T1_BASE(4'h1), .T2_BASE(4'h2), .T3_BASE(4'h3),
        .TIMEOUT(15)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          ack_cyc;     // 0 = target never acks
        int          stray_cyc;   // 0 = no stray ack
        logic [3:0]  stray_mask;
        logic [31:0] rdata;       // driven on the addressed target's rdata
        logic [3:0]  exp_sel;
        int          sel_cycles;  // t_sel expected high in cycles 1..sel_cycles
        int          rsp_cyc;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[7];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    task automatic drive_rdata(input logic [3:0] sel, input logic [31:0] val);
        bus.t_rdata0 = (sel == 4'b0001) ? val : 32'hA5A5_0000;
        bus.t_rdata1 = (sel == 4'b0010) ? val : 32'hA5A5_0001;
        bus.t_rdata2 = (sel == 4'b0100) ? val : 32'hA5A5_0002;
        bus.t_rdata3 = (sel == 4'b1000) ? val : 32'hA5A5_0003;
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        check({v.name, ".req_ready_c0"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = v.we;
        bus.req_addr  = v.addr;
        bus.req_wdata = v.wdata;
        bus.req_wstrb = v.wstrb;
        bus.t_ack     = 4'b0000;
        drive_rdata(v.exp_sel, v.rdata);
        for (int c = 1; c <= v.rsp_cyc; c++) begin
            @(negedge clk);
            // Scramble request fields after handshake; targets must see the latches.
            bus.req_valid = 1'b0;
            bus.req_we    = ~v.we;
            bus.req_addr  = ~v.addr;
            bus.req_wdata = ~v.wdata;
            bus.req_wstrb = ~v.wstrb;
            bus.t_ack = 4'b0000;
            if (c == v.ack_cyc)   bus.t_ack = bus.t_ack | v.exp_sel;
            if (c == v.stray_cyc) bus.t_ack = bus.t_ack | v.stray_mask;
            check({v.name, ".t_sel"}, 32'(bus.t_sel), (c <= v.sel_cycles) ? 32'(v.exp_sel) : 32'd0);
            check({v.name, ".req_ready_busy"}, 32'(bus.req_ready), 32'd0);
            if (c <= v.sel_cycles) begin
                check({v.name, ".t_addr"},  bus.t_addr, v.addr);
                check({v.name, ".t_we"},    32'(bus.t_we), 32'(v.we));
                check({v.name, ".t_wdata"}, bus.t_wdata, v.wdata);
                check({v.name, ".t_wstrb"}, 32'(bus.t_wstrb), 32'(v.wstrb));
            end
            check({v.name, ".rsp_valid"}, 32'(bus.rsp_valid), (c == v.rsp_cyc) ? 32'd1 : 32'd0);
            if (c == v.rsp_cyc) begin
                check({v.name, ".rsp_err"},   32'(bus.rsp_err), 32'(v.exp_err));
                check({v.name, ".rsp_rdata"}, bus.rsp_rdata, v.exp_rdata);
            end
        end
        @(negedge clk);
        bus.t_ack = 4'b0000;
        check({v.name, ".rsp_valid_after"}, 32'(bus.rsp_valid), 32'd0);
        check({v.name, ".req_ready_after"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        vecs[0] = '{"zero_wait_load", 1'b0, 32'h1000_0040, 32'h0, 4'h0, 1, 0, 4'h0,
                    32'hDEAD_BEEF, 4'b0010, 1, 2, 1'b0, 32'hDEAD_BEEF};
        vecs[1] = '{"wait_store", 1'b1, 32'h2000_0000, 32'h1234_5678, 4'b0011, 4, 2, 4'b0001,
                    32'hCAFE_F00D, 4'b0100, 4, 5, 1'b0, 32'h0};
        vecs[2] = '{"decode_miss", 1'b0, 32'h8000_0000, 32'h0, 4'h0, 0, 0, 4'h0,
                    32'h0, 4'b0000, 0, 1, 1'b1, 32'h0};
        vecs[3] = '{"timeout", 1'b0, 32'h3000_0000, 32'h0, 4'h0, 0, 0, 4'h0,
                    32'h5555_AAAA, 4'b1000, 15, 16, 1'b1, 32'h0};
        vecs[4] = '{"ack_at_limit", 1'b0, 32'h3000_0010, 32'h0, 4'h0, 15, 3, 4'b0111,
                    32'h0BAD_F00D, 4'b1000, 15, 16, 1'b0, 32'h0BAD_F00D};
        vecs[5] = '{"t0_wait_load", 1'b0, 32'h0000_0100, 32'h0, 4'h0, 2, 1, 4'b0010,
                    32'h1122_3344, 4'b0001, 2, 3, 1'b0, 32'h1122_3344};
        vecs[6] = '{"miss_clears_rdata", 1'b0, 32'hF000_0004, 32'h0, 4'h0, 0, 0, 4'h0,
                    32'h0, 4'b0000, 0, 1, 1'b1, 32'h0};

        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wstrb = '0;
        bus.t_ack     = '0;
        drive_rdata(4'b0000, 32'h0);
        reset = 1'b1;

        // Reset held for two cycles, then released.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("reset.t_sel",     32'(bus.t_sel), 32'd0);
            check("reset.rsp_valid", 32'(bus.rsp_valid), 32'd0);
            check("reset.req_ready", 32'(bus.req_ready), 32'd0);
        end
        check("reset.rsp_err",   32'(bus.rsp_err), 32'd0);
        check("reset.rsp_rdata", bus.rsp_rdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("release.req_ready", 32'(bus.req_ready), 32'd1);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset in cycle 2 of a pending target 0 access.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h0000_0200;
        drive_rdata(4'b0001, 32'h7777_7777);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("midrst.t_sel_c1", 32'(bus.t_sel), 32'h1);
        @(negedge clk);
        check("midrst.t_sel_c2", 32'(bus.t_sel), 32'h1);
        reset = 1'b1;
        check("midrst.req_ready_in_reset", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        check("midrst.t_sel_c3", 32'(bus.t_sel), 32'd0);
        for (int c = 4; c < 22; c++) begin
            @(negedge clk);
            check("midrst.no_rsp", 32'(bus.rsp_valid), 32'd0);
            check("midrst.t_sel_low", 32'(bus.t_sel), 32'd0);
        end
        run_vec(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bus_decoder.md
# bus_decoder

Single-request bus decoder and response router for the multicycle core's one memory port. It accepts one load/store request from the core, decodes the address to one of four target slaves (e.g. instruction ROM, data RAM, UART, timer), and drives that target's one-hot select with the latched request. It then waits for the target's acknowledge, or a timeout, and returns read data or an error to the core. It is the outbound counterpart of the core's read-data select: it fans one request out to the targets, and the core's mux selects the returned data.

## Interface
Parameters:
- T0_BASE, 4'h0: addr[31:28] value selecting target 0
- T1_BASE, 4'h1: addr[31:28] value selecting target 1
- T2_BASE, 4'h2: addr[31:28] value selecting target 2
- T3_BASE, 4'h3: addr[31:28] value selecting target 3
- TIMEOUT, 15: maximum number of ACCESS cycles spent waiting for an ack; legal range 1..255

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  core request valid
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- req_wstrb  in  4  store byte enables
- req_ready  out  1  block can accept a request
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  load data
- rsp_err  out  1  decode or timeout error, qualified by rsp_valid
- t_sel  out  4  one-hot target select
- t_we, t_addr[31:0], t_wdata[31:0], t_wstrb[3:0]  out  latched request fields, broadcast to all targets
- t_ack  in  4  per-target acknowledge
- t_rdata0..t_rdata3  in  32 each  per-target read data

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready = 1.
  - A handshake occurs when req_valid && req_ready; on it, latch req_we, req_addr, req_wdata and req_wstrb.
  - Decode req_addr[31:28] against T0..T3_BASE, giving sel_idx.
  - Decode hit: go to ACCESS and clear the timeout counter.
  - Decode miss: go to RESP with err=1 and rdata=0. No target is selected.
  - If two bases are equal, the lowest-numbered target wins.
- ACCESS:
  - t_sel = 1 << sel_idx; t_* fields are driven from the latches and held stable throughout.
  - Only t_ack[sel_idx] is honoured; acks from other targets are ignored.
  - On ack: capture the selected t_rdataN into rsp_rdata (loads only; stores return 0), set err=0, go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT with no ack: err=1, rdata=0, go to RESP.
  - If an ack arrives in the same cycle the counter reaches TIMEOUT, the ack wins.
- RESP:
  - rsp_valid = 1 for exactly one cycle with rsp_rdata and rsp_err stable, then go to IDLE.
  - The core has no backpressure on responses.
- Outputs outside their qualifying state:
  - t_sel = 0 outside ACCESS.
  - rsp_valid = 0 outside RESP.
  - rsp_rdata and rsp_err hold their last values but are meaningful only with rsp_valid.
- Only one outstanding request at a time; req_ready = 0 in ACCESS and RESP.
- Reset:
  - State goes to IDLE; counter, latches, rsp_rdata and rsp_err are cleared to 0; t_sel = 0; rsp_valid = 0.
  - req_ready = 0 while reset is high.
- Reset mid-operation: the in-flight request is dropped and no response is issued. t_sel is deasserted on the cycle after reset is sampled.

## Timing
- Cycle numbering: cycle 0 is the request handshake; cycle 1 is the first ACCESS cycle, with t_sel asserted.
- Zero-wait target (t_ack high in cycle 1): rsp_valid in cycle 2; req_ready is high again in cycle 3.
- Target acking in ACCESS cycle k: rsp_valid in cycle k+1.
- Decode miss: rsp_valid in cycle 1.
- Timeout: t_sel is high for cycles 1..TIMEOUT; rsp_valid with err in cycle TIMEOUT+1.
- Back-to-back requests: the minimum issue interval is 3 cycles (IDLE, ACCESS, RESP).
- No combinational path from t_ack or t_rdata to any output. All outputs are registered or decoded from state only, except req_ready, which is (state==IDLE) && !reset.

## Test plan
- Reset and idle:
  - Stimulus: hold reset for 2 cycles, then release.
  - Required: t_sel=0, rsp_valid=0 and req_ready=0 throughout reset; req_ready=1 in the first cycle after release.
- Zero-wait load:
  - Stimulus: load from addr 0x1000_0040; target 1 acks in cycle 1 with t_rdata1=0xDEAD_BEEF.
  - Required: t_sel=4'b0010 in cycle 1 only; rsp_valid in cycle 2 with rsp_rdata=0xDEAD_BEEF, rsp_err=0.
- Wait-state store:
  - Stimulus: store to 0x2000_0000, wdata 0x1234_5678, wstrb 4'b0011; target 2 acks in cycle 4; stray t_ack[0] in cycle 2.
  - Required: t_sel=4'b0100 held for cycles 1..4 with t_* fields stable; stray ack ignored; rsp_valid in cycle 5 with rsp_rdata=0, rsp_err=0.
- Decode miss:
  - Stimulus: load from addr 0x8000_0000.
  - Required: t_sel stays 0; rsp_valid in cycle 1 with rsp_err=1, rsp_rdata=0.
- Timeout and ack-at-limit:
  - Stimulus 1: TIMEOUT=15, target 3 never acks.
  - Required 1: t_sel=4'b1000 for 15 cycles; rsp_err=1 in cycle 16.
  - Stimulus 2: repeat with target 3 acking in cycle 15.
  - Required 2: rsp_err=0 in cycle 16 with the captured data.
- Reset mid-access:
  - Stimulus: assert reset in cycle 2 of a pending target 0 access.
  - Required: t_sel=0 from cycle 3; no rsp_valid pulse; the next request after reset completes normally.
